// File: rtl/conv_encoder_pkg.sv
// conv_encoder_pkg
// Shared definitions for the conv encoder layer tail: activation and product
// widths, the accumulator FSM state type and the activation clip limits.
// No ports; import with `import conv_encoder_pkg::*;`.
package conv_encoder_pkg;

    localparam int DATA_W = 18;   // signed activation width
    localparam int PROD_W = 36;   // signed PE product / bias width

    // Clip limits of a DATA_W-bit signed activation.
    localparam int OUT_MAX = (2 ** (DATA_W - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (DATA_W - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } acc_state_e;

endpackage

// File: rtl/conv_requant.sv
// conv_requant
// Combinational requantiser for layer tails: rounds a signed accumulator half
// toward +inf, arithmetic-shifts it right by FRAC_SHIFT and saturates it to a
// signed OUT_W-bit activation.
// Ports:
//   acc_i   in  ACC_W  signed accumulator value
//   data_o  out OUT_W  signed rounded, shifted and clipped result
//   sat_o   out 1      result was clipped to the OUT_W range
module conv_requant #(
    parameter int ACC_W      = 48,
    parameter int OUT_W      = 18,
    parameter int FRAC_SHIFT = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    // One guard bit so the rounding add can never wrap.
    localparam int EXT_W = ACC_W + 1;

    localparam logic [EXT_W-1:0] ONE = EXT_W'(1);
    // 2^(FRAC_SHIFT-1), which collapses to 0 when FRAC_SHIFT is 0.
    localparam logic [EXT_W-1:0] RND_HALF = (ONE << FRAC_SHIFT) >> 1;

    localparam logic signed [EXT_W-1:0] SAT_HI =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_LO =
        {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] ext;
        ext = {a[ACC_W-1], a};
        return (ext + signed'(RND_HALF)) >>> FRAC_SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [EXT_W-1:0] r);
        if (r > SAT_HI) begin
            return {1'b1, SAT_HI[OUT_W-1:0]};
        end else if (r < SAT_LO) begin
            return {1'b1, SAT_LO[OUT_W-1:0]};
        end
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    assign {sat_o, data_o} = saturate(round_shift(signed'(acc_i)));

endmodule

// File: rtl/conv_encoder_accumulator.sv
// conv_encoder_accumulator
// Tail stage of the conv encoder PE: accumulates KERNEL_TAPS signed products on
// top of a per-window bias, requantises the sum to an OUT_W activation and hands
// it downstream over a valid/ready handshake.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin a window (IDLE only); bias sampled with it
//   bias       PROD_W signed window bias
//   in_valid   product present on in_z
//   in_z       PROD_W signed product
//   in_ready   product accepted this cycle (ACCUM only)
//   out_valid  out_data holds a finished activation
//   out_data   OUT_W signed activation
//   out_ready  downstream accepts out_data
//   busy       FSM is not IDLE
//   sat_flag   out_data was clipped
module conv_encoder_accumulator
    import conv_encoder_pkg::*;
#(
    parameter int KERNEL_TAPS = 9,
    parameter int PROD_W      = conv_encoder_pkg::PROD_W,
    parameter int ACC_W       = 48,
    parameter int FRAC_SHIFT  = 16,
    parameter int OUT_W       = conv_encoder_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] bias,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_z,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              sat_flag
);

    if (KERNEL_TAPS < 1) begin : g_bad_taps
        $error("conv_encoder_accumulator: KERNEL_TAPS must be >= 1");
    end
    if (ACC_W < PROD_W + $clog2(KERNEL_TAPS) + 1) begin : g_bad_acc_w
        $error("conv_encoder_accumulator: ACC_W too small for KERNEL_TAPS products");
    end

    // Wide enough to hold KERNEL_TAPS itself, which also covers KERNEL_TAPS == 1.
    localparam int CNT_W = $clog2(KERNEL_TAPS + 1);

    acc_state_e              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OUT_W-1:0]        out_data_q;
    logic                    sat_q;

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] z_ext;
    logic [OUT_W-1:0]        rq_data;
    logic                    rq_sat;
    logic                    last_tap;

    assign bias_ext = {{(ACC_W - PROD_W){bias[PROD_W-1]}}, bias};
    assign z_ext    = {{(ACC_W - PROD_W){in_z[PROD_W-1]}}, in_z};
    assign last_tap = (cnt_q == CNT_W'(KERNEL_TAPS - 1));

    conv_requant #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_requant (
        .acc_i  (acc_q),
        .data_o (rq_data),
        .sat_o  (rq_sat)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            // Result only changes in ROUND, so it stays frozen through OUT
            // backpressure and lingers (unqualified) in IDLE.
            if (state_q == ROUND) begin
                out_data_q <= rq_data;
                sat_q      <= rq_sat;
            end
        end
    end

    // Next-state and accumulator update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + z_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_tap) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        out_data  = out_data_q;
        sat_flag  = sat_q;
    end

endmodule
